// File: rtl/regfile_sb_if.sv
// Issue/read/write/AGU bundle between decode and the register file.
// The master drives addresses, write data and AGU requests; the slave returns read data, busy flags and the address result.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) ();
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rv1;
    logic [XLEN-1:0] rv2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            we;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wdata;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic [1:0]      agu_mode;
    logic [31:0]     instr;
    logic [XLEN-1:0] daddr;
    logic            daddr_valid;
    logic            misaligned;

    modport master (
        output rs1, rs2, we, rd, wdata, issue_valid, issue_rd, agu_mode, instr,
        input  rv1, rv2, rs1_busy, rs2_busy, daddr, daddr_valid, misaligned
    );

    modport slave (
        input  rs1, rs2, we, rd, wdata, issue_valid, issue_rd, agu_mode, instr,
        output rv1, rv2, rs1_busy, rs2_busy, daddr, daddr_valid, misaligned
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two bypassed read ports, one write port, a busy scoreboard
// and a one-cycle load/store address generator with alignment checking.
module regfile_sb #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int AW      = $clog2(NREGS),
    parameter int R0_ZERO = 1,
    parameter int BYPASS  = 1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);
    // Handshake: there is no back-pressure. we/issue_valid/agu_mode are accepted on
    // every posedge they are asserted; daddr_valid is a one-cycle pulse, one per request,
    // and daddr/misaligned describe that request only while daddr_valid is high.

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             wr_ok;
    logic             iss_ok;
    logic             fwd1;
    logic             fwd2;
    logic [11:0]      imm;
    logic             agu_req;
    logic [XLEN-1:0]  ea;
    logic [1:0]       size;
    logic             mis;

    assign wr_ok  = bus.we && !((R0_ZERO != 0) && (bus.rd == '0));
    assign iss_ok = bus.issue_valid && !((R0_ZERO != 0) && (bus.issue_rd == '0));
    assign fwd1   = (BYPASS != 0) && wr_ok && (bus.rd == bus.rs1);
    assign fwd2   = (BYPASS != 0) && wr_ok && (bus.rd == bus.rs2);

    always_comb begin
        bus.rv1 = fwd1 ? bus.wdata : mem[bus.rs1];
        bus.rv2 = fwd2 ? bus.wdata : mem[bus.rs2];
        if ((R0_ZERO != 0) && (bus.rs1 == '0)) bus.rv1 = '0;
        if ((R0_ZERO != 0) && (bus.rs2 == '0)) bus.rv2 = '0;
    end

    always_comb begin
        bus.rs1_busy = busy[bus.rs1] && !fwd1;
        bus.rs2_busy = busy[bus.rs2] && !fwd2;
        if ((R0_ZERO != 0) && (bus.rs1 == '0)) bus.rs1_busy = 1'b0;
        if ((R0_ZERO != 0) && (bus.rs2 == '0)) bus.rs2_busy = 1'b0;
    end

    // Clear before set so a same-cycle issue to the written register leaves it busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok)  busy_nxt[bus.rd]       = 1'b0;
        if (iss_ok) busy_nxt[bus.issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) mem[bus.rd] <= bus.wdata;
            busy <= busy_nxt;
        end
    end

    always_comb begin
        imm     = 12'd0;
        agu_req = 1'b0;
        case (bus.agu_mode)
            2'd1: begin
                imm     = bus.instr[31:20];
                agu_req = 1'b1;
            end
            2'd2: begin
                imm     = {bus.instr[31:25], bus.instr[11:7]};
                agu_req = 1'b1;
            end
            default: ;
        endcase
    end

    assign ea   = bus.rv1 + {{(XLEN-12){imm[11]}}, imm};
    assign size = bus.instr[13:12];

    always_comb begin
        mis = 1'b0;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = ea[0];
            2'd2:    mis = |ea[1:0];
            default: mis = (XLEN == 32) ? 1'b1 : |ea[2:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.daddr       <= '0;
            bus.daddr_valid <= 1'b0;
            bus.misaligned  <= 1'b0;
        end else if (agu_req) begin
            bus.daddr       <= ea;
            bus.daddr_valid <= 1'b1;
            bus.misaligned  <= mis;
        end else begin
            bus.daddr_valid <= 1'b0;
        end
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the core's register file. It provides two combinational read ports with optional write-to-read bypass, one synchronous write port, a per-register busy scoreboard for in-flight writes, and a registered load/store address generator (AGU) that also checks alignment. It sits between decode, which issues to it, and writeback/memory, which consume its outputs.

Parameters:
XLEN, 32, data width in bits; legal values are 32 and 64.
NREGS, 32, number of architectural registers; must be a power of two, at least 2.
AW, $clog2(NREGS), register address width (derived).
R0_ZERO, 1, when 1, register 0 reads as 0 and ignores writes and issues.
BYPASS, 1, when 1, a same-cycle write is forwarded to the read ports.

Ports:
clk  in  1  clock; all state updates on the posedge
rst_n  in  1  asynchronous, active-low reset
rs1  in  AW  read address, port 1
rs2  in  AW  read address, port 2
rv1  out  XLEN  read data, port 1 (combinational)
rv2  out  XLEN  read data, port 2 (combinational)
rs1_busy  out  1  rs1 has a pending write (combinational)
rs2_busy  out  1  rs2 has a pending write (combinational)
we  in  1  write enable
rd  in  AW  write address
wdata  in  XLEN  write data
issue_valid  in  1  marks issue_rd busy
issue_rd  in  AW  destination register of the issued instruction
agu_mode  in  2  0 = none, 1 = I-type (load), 2 = S-type (store), 3 = reserved (treated as none)
instr  in  32  instruction word; immediate fields and instr[13:12] size
daddr  out  XLEN  registered effective address
daddr_valid  out  1  daddr is valid this cycle
misaligned  out  1  alignment fault for the access in daddr, valid with daddr_valid

Behaviour:
- Reset (async assert, sync release): all registers, busy bits, daddr, daddr_valid and misaligned clear to 0.
- Read: rvN = mem[rsN].
  - If R0_ZERO and rsN==0, rvN = 0.
  - If BYPASS and we and rd==rsN and the write is not suppressed, rvN = wdata.
- Write: on posedge, if we and not (R0_ZERO and rd==0), mem[rd] <= wdata. No X-filtering and no level-sensitive writes.
- Scoreboard, per register:
  - issue_valid sets busy[issue_rd]; it is ignored for register 0 when R0_ZERO.
  - A write (we) clears busy[rd].
  - If issue and write target the same register in the same cycle, busy ends set; the issue wins.
- Busy outputs: rsN_busy = busy[rsN], except it reads 0 when BYPASS and a write to rsN occurs this cycle.
  - With R0_ZERO, busy for register 0 is always 0.
- AGU:
  - Sampled on the posedge when agu_mode is 1 or 2.
  - Effective address uses the bypassed rv1 plus a sign-extended immediate, extended to XLEN:
    - mode 1: instr[31:20]
    - mode 2: {instr[31:25], instr[11:7]}
  - Sum wraps modulo 2^XLEN.
  - Latency is 1 cycle: daddr and daddr_valid are asserted the following cycle. daddr_valid is a single-cycle pulse per request; back-to-back requests give back-to-back pulses.
  - When not sampling, daddr holds its value and daddr_valid = 0.
- Misaligned, from size = instr[13:12]:
  - 0: byte, never misaligned
  - 1: half, misaligned if addr[0]
  - 2: word, misaligned if addr[1:0] != 0
  - 3: misaligned if XLEN == 32; for XLEN == 64, misaligned if addr[2:0] != 0
- The AGU does not stall on rs1_busy; decode is responsible for interlocking.
- Reset asserted mid-request: daddr_valid drops immediately and the request is lost.

Test Plan:
- Reset then read all registers: every rv = 0, every busy = 0; write x5 = 0xDEADBEEF, next cycle rs1 = 5 gives rv1 = 0xDEADBEEF.
- R0_ZERO: we = 1, rd = 0, wdata = 0x1234 and issue_rd = 0 -> rv1 with rs1 = 0 stays 0, rs1_busy = 0.
- Bypass: same cycle we = 1, rd = 7, wdata = 0xA5A5A5A5, rs2 = 7 -> rv2 = 0xA5A5A5A5 combinationally, rs2_busy = 0; with BYPASS = 0, rv2 returns the old value.
- Scoreboard: issue x3 -> rs1_busy = 1 with rs1 = 3; in a later cycle issue x3 and write x3 together -> still busy; a write alone clears it.
- AGU load: x2 = 0x1000, instr imm = 0xFFC (-4), size = 2, mode = 1 -> one cycle later daddr = 0x0FFC, daddr_valid = 1, misaligned = 0; imm = 0x002 gives misaligned = 1.
- AGU store with wrap: x1 = 0xFFFFFFFE, S-imm = 4, size = 1 -> daddr = 0x00000002, misaligned = 0; assert rst_n = 0 in the next request cycle -> daddr_valid = 0 immediately.
